// File: rtl/aibcr3_dll_pkg.sv
// Shared definitions for the strobe-align DLL delay-code controller.
// States, vote direction encoding and the binary-to-gray helper.
package aibcr3_dll_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_DECIDE = 3'd4;
  localparam logic [2:0] ST_LOCKED = 3'd5;
  localparam logic [2:0] ST_OVR    = 3'd6;

  typedef enum logic [1:0] {
    DIR_TIE = 2'd0,
    DIR_UP  = 2'd1,
    DIR_DN  = 2'd2
  } dir_e;

  // Callers zero-extend narrower fields and width-cast the result back down.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/aibcr3_dll_vote_win.sv
// Phase-detector vote window: counts 2**VOTE_W enabled cycles, accumulates the
// signed up/down balance and reports the window direction with a done pulse.
module aibcr3_dll_vote_win
  import aibcr3_dll_pkg::*;
#(
  parameter int VOTE_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic t_up,
  input  logic t_down,
  output logic win_done,
  output dir_e dir
);

  logic [VOTE_W-1:0]        cnt_q, cnt_d;
  logic signed [VOTE_W:0]   net_q, net_d;
  logic signed [VOTE_W+1:0] net_final;
  logic [1:0]               vote;
  dir_e                     dir_q, dir_d;

  // The last vote is folded in combinationally, so the register only ever
  // holds 2**VOTE_W-1 votes and cannot overflow.
  always_comb begin
    if (t_up && !t_down) begin
      vote = 2'b01;
    end else if (t_down && !t_up) begin
      vote = 2'b11;
    end else begin
      vote = 2'b00;
    end
    net_final = {net_q[VOTE_W], net_q} + {{VOTE_W{vote[1]}}, vote};
    win_done  = en && (cnt_q == {VOTE_W{1'b1}});

    cnt_d = cnt_q;
    net_d = net_q;
    dir_d = dir_q;
    if (clr) begin
      cnt_d = {VOTE_W{1'b0}};
      net_d = {(VOTE_W+1){1'b0}};
    end else if (win_done) begin
      cnt_d = {VOTE_W{1'b0}};
      net_d = {(VOTE_W+1){1'b0}};
      if (net_final[VOTE_W+1]) begin
        dir_d = DIR_DN;
      end else if (net_final != {(VOTE_W+2){1'b0}}) begin
        dir_d = DIR_UP;
      end else begin
        dir_d = DIR_TIE;
      end
    end else if (en) begin
      cnt_d = cnt_q + {{(VOTE_W-1){1'b0}}, 1'b1};
      net_d = net_final[VOTE_W:0];
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {VOTE_W{1'b0}};
      net_q <= {(VOTE_W+1){1'b0}};
      dir_q <= DIR_TIE;
    end else begin
      cnt_q <= cnt_d;
      net_q <= net_d;
      dir_q <= dir_d;
    end
  end

  assign dir = dir_q;

endmodule

// File: rtl/aibcr3_dll_code_ctrl.sv
// DLL delay-code controller: settle/sample/decide loop, code stepping with
// saturation, lock acquisition and loss tracking, CSR override, gray selects.
module aibcr3_dll_code_ctrl
  import aibcr3_dll_pkg::*;
#(
  parameter int CODE_W     = 10,
  parameter int FINE_W     = 3,
  parameter int VOTE_W     = 4,
  parameter int LOCK_CNT   = 8,
  parameter int SETTLE_CYC = 4
) (
  input  logic                     clk_pll,
  input  logic                     reset,
  input  logic                     t_up,
  input  logic                     t_down,
  input  logic                     lock_req,
  input  logic                     half_code_en,
  input  logic                     csr_code_ovr,
  input  logic [CODE_W-1:0]        csr_code,
  input  logic                     rb_selflock,
  output logic [CODE_W-1:0]        code_bin,
  output logic [CODE_W-FINE_W-1:0] f_gray,
  output logic [FINE_W-1:0]        i_gray,
  output logic                     code_valid,
  output logic                     dll_lock,
  output logic                     sat_hi,
  output logic                     sat_lo
);

  localparam int COARSE_W = CODE_W - FINE_W;
  localparam int LCNT_W   = $clog2(LOCK_CNT + 1);
  localparam int SCNT_W   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CODE_W-1:0] CODE_MAX    = {CODE_W{1'b1}};
  localparam logic [CODE_W-1:0] CODE_ZERO   = {CODE_W{1'b0}};
  localparam logic [CODE_W-1:0] CODE_ONE    = {{(CODE_W-1){1'b0}}, 1'b1};
  localparam logic [CODE_W-1:0] CODE_MID    = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic [LCNT_W-1:0] LOCK_TGT    = LCNT_W'(LOCK_CNT);
  localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(SETTLE_CYC - 1);

  logic [2:0]          state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [SCNT_W-1:0]   settle_q, settle_d;
  logic [LCNT_W-1:0]   lock_cnt_q, lock_cnt_d, lock_inc;
  dir_e                prev_dir_q, prev_dir_d;
  logic                drift_q, drift_d;
  logic                code_valid_q, code_valid_d;
  logic                dll_lock_q, dll_lock_d;
  logic                sat_hi_q, sat_hi_d;
  logic                sat_lo_q, sat_lo_d;
  logic [COARSE_W-1:0] f_gray_q, f_gray_d;
  logic [FINE_W-1:0]   i_gray_q, i_gray_d;

  logic win_en, win_clr, win_done;
  logic sat_now, same_dir, opp_dir;
  dir_e win_dir;

  assign win_en  = (state_q == ST_SAMPLE) || (state_q == ST_LOCKED);
  assign win_clr = !win_en;

  aibcr3_dll_vote_win #(.VOTE_W(VOTE_W)) u_vote_win (
    .clk      (clk_pll),
    .rst      (reset),
    .clr      (win_clr),
    .en       (win_en),
    .t_up     (t_up),
    .t_down   (t_down),
    .win_done (win_done),
    .dir      (win_dir)
  );

  // Next-state, code, lock and saturation decisions.
  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    settle_d     = settle_q;
    lock_cnt_d   = lock_cnt_q;
    prev_dir_d   = prev_dir_q;
    drift_d      = drift_q;
    code_valid_d = code_valid_q;
    dll_lock_d   = dll_lock_q;
    sat_hi_d     = sat_hi_q;
    sat_lo_d     = sat_lo_q;
    lock_inc     = lock_cnt_q + LCNT_W'(1'b1);
    sat_now  = ((win_dir == DIR_UP) && (code_q == CODE_MAX)) ||
               ((win_dir == DIR_DN) && (code_q == CODE_ZERO));
    same_dir = (win_dir != DIR_TIE) && (win_dir == prev_dir_q);
    opp_dir  = (win_dir != DIR_TIE) && (prev_dir_q != DIR_TIE) && (win_dir != prev_dir_q);

    if (csr_code_ovr) begin
      state_d      = ST_OVR;
      code_d       = csr_code;
      code_valid_d = 1'b1;
      dll_lock_d   = rb_selflock;
      sat_hi_d     = 1'b0;
      sat_lo_d     = 1'b0;
      settle_d     = {SCNT_W{1'b0}};
      lock_cnt_d   = {LCNT_W{1'b0}};
      drift_d      = 1'b0;
    end else if ((state_q == ST_OVR) || !lock_req) begin
      state_d      = ST_IDLE;
      code_valid_d = 1'b0;
      dll_lock_d   = 1'b0;
      settle_d     = {SCNT_W{1'b0}};
      lock_cnt_d   = {LCNT_W{1'b0}};
      drift_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_INIT;
        ST_INIT: begin
          code_d       = half_code_en ? CODE_MID : CODE_ZERO;
          code_valid_d = 1'b1;
          dll_lock_d   = 1'b0;
          sat_hi_d     = 1'b0;
          sat_lo_d     = 1'b0;
          lock_cnt_d   = {LCNT_W{1'b0}};
          prev_dir_d   = DIR_TIE;
          drift_d      = 1'b0;
          settle_d     = {SCNT_W{1'b0}};
          state_d      = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            settle_d = {SCNT_W{1'b0}};
            state_d  = dll_lock_q ? ST_LOCKED : ST_SAMPLE;
          end else begin
            settle_d = settle_q + SCNT_W'(1'b1);
          end
        end
        ST_SAMPLE, ST_LOCKED: begin
          state_d = win_done ? ST_DECIDE : state_q;
        end
        ST_DECIDE: begin
          if (win_dir == DIR_UP) begin
            sat_hi_d = sat_now;
            sat_lo_d = 1'b0;
            code_d   = sat_now ? code_q : code_q + CODE_ONE;
          end else if (win_dir == DIR_DN) begin
            sat_hi_d = 1'b0;
            sat_lo_d = sat_now;
            code_d   = sat_now ? code_q : code_q - CODE_ONE;
          end else begin
            sat_hi_d = 1'b0;
            sat_lo_d = 1'b0;
          end
          if (win_dir != DIR_TIE) begin
            prev_dir_d = win_dir;
          end else begin
            prev_dir_d = prev_dir_q;
          end
          // Locked: a repeat of a repeat means the loop is drifting away.
          if (dll_lock_q) begin
            if (same_dir && drift_q) begin
              dll_lock_d = 1'b0;
              lock_cnt_d = {LCNT_W{1'b0}};
              drift_d    = 1'b0;
            end else if (same_dir) begin
              drift_d = 1'b1;
            end else if (opp_dir) begin
              drift_d = 1'b0;
            end else begin
              drift_d = drift_q;
            end
          end else if (sat_now) begin
            lock_cnt_d = {LCNT_W{1'b0}};
          end else if ((win_dir == DIR_TIE) || opp_dir) begin
            lock_cnt_d = lock_inc;
            if (lock_inc == LOCK_TGT) begin
              dll_lock_d = 1'b1;
              drift_d    = 1'b0;
            end else begin
              dll_lock_d = 1'b0;
            end
          end else begin
            lock_cnt_d = {LCNT_W{1'b0}};
          end
          if (code_d != code_q) begin
            state_d = ST_SETTLE;
          end else begin
            state_d = dll_lock_d ? ST_LOCKED : ST_SAMPLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    f_gray_d = COARSE_W'(bin2gray(32'(code_d[CODE_W-1:FINE_W])));
    i_gray_d = FINE_W'(bin2gray(32'(code_d[FINE_W-1:0])));
  end

  always_ff @(posedge clk_pll or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      code_q       <= {CODE_W{1'b0}};
      settle_q     <= {SCNT_W{1'b0}};
      lock_cnt_q   <= {LCNT_W{1'b0}};
      prev_dir_q   <= DIR_TIE;
      drift_q      <= 1'b0;
      code_valid_q <= 1'b0;
      dll_lock_q   <= 1'b0;
      sat_hi_q     <= 1'b0;
      sat_lo_q     <= 1'b0;
      f_gray_q     <= {COARSE_W{1'b0}};
      i_gray_q     <= {FINE_W{1'b0}};
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      settle_q     <= settle_d;
      lock_cnt_q   <= lock_cnt_d;
      prev_dir_q   <= prev_dir_d;
      drift_q      <= drift_d;
      code_valid_q <= code_valid_d;
      dll_lock_q   <= dll_lock_d;
      sat_hi_q     <= sat_hi_d;
      sat_lo_q     <= sat_lo_d;
      f_gray_q     <= f_gray_d;
      i_gray_q     <= i_gray_d;
    end
  end

  assign code_bin   = code_q;
  assign f_gray     = f_gray_q;
  assign i_gray     = i_gray_q;
  assign code_valid = code_valid_q;
  assign dll_lock   = dll_lock_q;
  assign sat_hi     = sat_hi_q;
  assign sat_lo     = sat_lo_q;

endmodule

// File: tb/tb_aibcr3_dll_code_ctrl.sv
// Directed bench for aibcr3_dll_code_ctrl: acquisition, saturation, lock/unlock,
// lock_req drop, CSR override and asynchronous reset.
module tb_aibcr3_dll_code_ctrl;

  logic       clk_pll      = 1'b0;
  logic       reset        = 1'b1;
  logic       t_up         = 1'b0;
  logic       t_down       = 1'b0;
  logic       lock_req     = 1'b0;
  logic       half_code_en = 1'b0;
  logic       csr_code_ovr = 1'b0;
  logic [9:0] csr_code     = 10'd0;
  logic       rb_selflock  = 1'b0;
  logic [9:0] code_bin;
  logic [6:0] f_gray;
  logic [2:0] i_gray;
  logic       code_valid, dll_lock, sat_hi, sat_lo;

  int  n_chk  = 0;
  int  n_fail = 0;
  bit  pd_mode = 1'b0;
  int  guard;
  int  cv_drop;
  logic [9:0] held;

  always #5 clk_pll = ~clk_pll;

  aibcr3_dll_code_ctrl dut (
    .clk_pll      (clk_pll),
    .reset        (reset),
    .t_up         (t_up),
    .t_down       (t_down),
    .lock_req     (lock_req),
    .half_code_en (half_code_en),
    .csr_code_ovr (csr_code_ovr),
    .csr_code     (csr_code),
    .rb_selflock  (rb_selflock),
    .code_bin     (code_bin),
    .f_gray       (f_gray),
    .i_gray       (i_gray),
    .code_valid   (code_valid),
    .dll_lock     (dll_lock),
    .sat_hi       (sat_hi),
    .sat_lo       (sat_lo)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Phase detector model: wants code 600, so the loop dithers 600/601.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      if (pd_mode) begin
        t_up   = (code_bin <= 10'd600);
        t_down = (code_bin > 10'd600);
      end
      @(posedge clk_pll);
      #1;
    end
  endtask

  initial begin
    tick(3);
    chk("rst_code",  32'(code_bin),   32'd0);
    chk("rst_valid", 32'(code_valid), 32'd0);
    chk("rst_lock",  32'(dll_lock),   32'd0);
    chk("rst_sat",   32'({sat_hi, sat_lo}), 32'd0);
    chk("rst_gray",  32'({f_gray, i_gray}), 32'd0);

    // Steady up votes from mid-code: one step every 21 cycles up to saturation.
    reset = 1'b0; half_code_en = 1'b1; t_up = 1'b1; lock_req = 1'b1;
    tick(2);
    chk("init_code",  32'(code_bin),   32'd512);
    chk("init_valid", 32'(code_valid), 32'd1);
    chk("init_fgray", 32'(f_gray),     32'h60);
    chk("init_igray", 32'(i_gray),     32'd0);
    tick(20);
    chk("hold_512",   32'(code_bin),   32'd512);
    tick(1);
    chk("step_513",   32'(code_bin),   32'd513);
    chk("igray_513",  32'(i_gray),     32'd1);
    tick(21);
    chk("step_514",   32'(code_bin),   32'd514);
    chk("igray_514",  32'(i_gray),     32'd3);
    guard = 0;
    while (code_bin != 10'd1023 && guard < 11000) begin
      tick(1);
      guard++;
    end
    chk("reach_1023", 32'(guard < 11000), 32'd1);
    chk("sat_hi_pre", 32'(sat_hi), 32'd0);
    tick(21);
    chk("sat_hi",     32'(sat_hi),   32'd1);
    chk("sat_hold",   32'(code_bin), 32'd1023);
    chk("sat_nolock", 32'(dll_lock), 32'd0);

    // Acquire against the PD model and lock on the 600/601 dither.
    reset = 1'b1;
    tick(2);
    reset = 1'b0; t_up = 1'b0; pd_mode = 1'b1;
    tick(2);
    cv_drop = 0; guard = 0;
    while (!dll_lock && guard < 4000) begin
      if (!code_valid) cv_drop++;
      tick(1);
      guard++;
    end
    chk("lock_seen",    32'(guard < 4000), 32'd1);
    chk("lock_code",    32'(code_bin), 32'd601);
    chk("lock_valid",   32'(cv_drop),  32'd0);

    // Drift downward: lock is lost on the second repeated down decision.
    pd_mode = 1'b0; t_up = 1'b0; t_down = 1'b1;
    guard = 0;
    while (dll_lock && guard < 300) begin
      tick(1);
      guard++;
    end
    chk("unlock_seen",  32'(guard < 300), 32'd1);
    chk("unlock_code",  32'(code_bin), 32'd598);

    // Relock, then drop lock_req.
    pd_mode = 1'b1;
    guard = 0;
    while (!dll_lock && guard < 2000) begin
      tick(1);
      guard++;
    end
    chk("relock_seen",  32'(guard < 2000), 32'd1);
    held = code_bin;
    pd_mode = 1'b0; lock_req = 1'b0;
    tick(1);
    chk("drop_lock",    32'(dll_lock),   32'd0);
    chk("drop_valid",   32'(code_valid), 32'd0);
    chk("drop_code",    32'(code_bin),   32'(held));

    // Start at code 0 with down votes: saturates low, never locks.
    half_code_en = 1'b0; t_up = 1'b0; t_down = 1'b1; lock_req = 1'b1;
    tick(2);
    chk("zero_code",    32'(code_bin), 32'd0);
    chk("zero_satlo0",  32'(sat_lo),   32'd0);
    tick(21);
    chk("sat_lo",       32'(sat_lo),   32'd1);
    chk("sat_lo_code",  32'(code_bin), 32'd0);
    tick(200);
    chk("sat_lo_nolock", 32'(dll_lock), 32'd0);

    // CSR override mid-acquire, tracked every cycle, then released.
    csr_code_ovr = 1'b1; csr_code = 10'h2A5; rb_selflock = 1'b1;
    tick(1);
    chk("ovr_code",  32'(code_bin),   32'h2A5);
    chk("ovr_fgray", 32'(f_gray),     32'h7E);
    chk("ovr_igray", 32'(i_gray),     32'h7);
    chk("ovr_lock",  32'(dll_lock),   32'd1);
    chk("ovr_valid", 32'(code_valid), 32'd1);
    csr_code = 10'h001; rb_selflock = 1'b0;
    tick(1);
    chk("ovr_track", 32'(code_bin),   32'h001);
    chk("ovr_rb0",   32'(dll_lock),   32'd0);
    csr_code_ovr = 1'b0;
    tick(1);
    chk("ovr_exit_valid", 32'(code_valid), 32'd0);
    chk("ovr_exit_code",  32'(code_bin),   32'h001);

    // Asynchronous reset in the middle of a sample window.
    half_code_en = 1'b1; t_up = 1'b1; t_down = 1'b0;
    tick(10);
    chk("pre_rst_code", 32'(code_bin), 32'd512);
    #2 reset = 1'b1;
    #1;
    chk("arst_code",  32'(code_bin),   32'd0);
    chk("arst_valid", 32'(code_valid), 32'd0);
    chk("arst_gray",  32'({f_gray, i_gray}), 32'd0);
    chk("arst_flags", 32'({dll_lock, sat_hi, sat_lo}), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
